// File: rtl/ireg_file.sv
// ireg_file: integer register file for the OSECPU core.
// Two combinational read ports, one synchronous write port, a per-register
// pending (scoreboard) bit for decode-stage hazard detection, and a hardware
// clear of every register after reset, with a ready flag raised when it ends.
// Optional build macro: IREG_BYPASS_EN forwards a same-cycle write to the
// read ports. Without it, a write becomes visible the cycle after its edge.
module ireg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] r0,
    input  logic [ADDR_W-1:0] r1,
    output logic [DATA_W-1:0] d0,
    output logic [DATA_W-1:0] d1,
    output logic              busy0,
    output logic              busy1,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] dw,
    input  logic              we,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              ready
);

    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              ready_reg;
    logic [NREGS-1:0]  pending_reg;
    logic [DATA_W-1:0] mem [NREGS];

    // Control FSM: walks the clear counter after reset, then tracks pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= CLEAR;
            cnt_reg     <= '0;
            ready_reg   <= 1'b0;
            pending_reg <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    cnt_reg <= cnt_reg + ADDR_W'(1);
                    if (cnt_reg == ADDR_W'(NREGS - 1)) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    // The reserve assignment comes last so it wins on an address clash.
                    if (we) begin
                        pending_reg[rw] <= 1'b0;
                    end
                    if (rsv) begin
                        pending_reg[rsv_addr] <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= CLEAR;
                end
            endcase
        end
    end

    // Storage: zeroed one entry per cycle while clearing, then written by writeback.
    // It has no reset of its own, so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
            mem[cnt_reg] <= '0;
        end else if (we) begin
            mem[rw] <= dw;
        end
    end

    // Read ports, one identical slice per port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [ADDR_W-1:0] addr_c;
            logic [DATA_W-1:0] data_c;
            logic              busy_c;

            assign addr_c = (gi == 0) ? r0 : r1;

            // Zero-latency read of stored data and pending state, with optional forwarding.
            always_comb begin
                data_c = mem[addr_c];
                busy_c = pending_reg[addr_c];
`ifdef IREG_BYPASS_EN
                if ((state_reg == RUN) && we && (rw == addr_c)) begin
                    data_c = dw;
                    busy_c = rsv && (rsv_addr == rw);
                end
`endif
            end
        end
    endgenerate

    assign d0    = g_port[0].data_c;
    assign d1    = g_port[1].data_c;
    assign busy0 = g_port[0].busy_c;
    assign busy1 = g_port[1].busy_c;
    assign ready = ready_reg;

endmodule

// File: tb/tb_ireg_file.sv
// tb_ireg_file: directed, table-driven bench for ireg_file, plus hand-written
// sequences for the reset, clear, interrupted-clear and forwarding cases.
module tb_ireg_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  r0 = '0, r1 = '0, rw = '0, rsv_addr = '0;
    logic [31:0] dw = '0;
    logic        we = 1'b0, rsv = 1'b0;
    logic [31:0] d0, d1;
    logic        busy0, busy1, ready;

    int n_cmp = 0;
    int n_fail = 0;

    ireg_file #(.DATA_W(32), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0(r0), .r1(r1), .d0(d0), .d1(d1),
        .busy0(busy0), .busy1(busy1),
        .rw(rw), .dw(dw), .we(we),
        .rsv(rsv), .rsv_addr(rsv_addr),
        .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [5:0]  rw;
        logic [31:0] dw;
        logic        rsv;
        logic [5:0]  rsv_addr;
        logic [5:0]  r0;
        logic [5:0]  r1;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic        exp_b0;
        logic        exp_b1;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0;
        rsv = 1'b0;
    endtask

    // Called at a negedge: hold reset low for three cycles, then release at a negedge.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("ready_async_drop", {31'b0, ready}, 32'd0);
        chk("busy0_in_reset", {31'b0, busy0}, 32'd0);
        chk("busy1_in_reset", {31'b0, busy1}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts right after rst_n rises at a negedge. Checks that ready rises exactly
    // on the 64th edge. Optionally drives a write+reserve to reg 2 before edge
    // inject_at, or re-asserts reset after edge abort_after. Returns at a negedge.
    task automatic clear_seq(input int inject_at, input int abort_after);
        for (int k = 1; k <= 64; k++) begin
            if (k == inject_at) begin
                we = 1'b1; rw = 6'd2; dw = 32'h55;
                rsv = 1'b1; rsv_addr = 6'd2; r0 = 6'd2;
            end
            @(posedge clk);
            #1;
            if (k == inject_at) begin
                idle();
                chk("busy0_during_clear", {31'b0, busy0}, 32'd0);
            end
            chk($sformatf("ready_edge%0d", k), {31'b0, ready}, (k == 64) ? 32'd1 : 32'd0);
            if (k == abort_after) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("ready_abort_clear", {31'b0, ready}, 32'd0);
                return;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vt[0] = '{1'b1, 6'd5,  32'h3,        1'b0, 6'd0, 6'd0,  6'd1,  32'h0,        32'h0,  1'b0, 1'b0};
        vt[1] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd7, 6'd5,  6'd4,  32'h3,        32'h0,  1'b0, 1'b0};
        vt[2] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 6'd7,  6'd5,  32'h0,        32'h3,  1'b1, 1'b0};
        vt[3] = '{1'b1, 6'd7,  32'hDEADBEEF, 1'b0, 6'd0, 6'd5,  6'd5,  32'h3,        32'h3,  1'b0, 1'b0};
        vt[4] = '{1'b1, 6'd9,  32'h99,       1'b1, 6'd9, 6'd7,  6'd7,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        vt[5] = '{1'b1, 6'd63, 32'hFFFFFFFF, 1'b0, 6'd0, 6'd9,  6'd0,  32'h99,       32'h0,  1'b1, 1'b0};
        vt[6] = '{1'b1, 6'd10, 32'hA,        1'b1, 6'd9, 6'd63, 6'd9,  32'hFFFFFFFF, 32'h99, 1'b0, 1'b1};
        vt[7] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 6'd9,  6'd10, 32'h99,       32'hA,  1'b1, 1'b0};

        // Reset release and full clear.
        @(negedge clk);
        reset_pulse();
        clear_seq(0, 0);
        for (int a = 0; a < 64; a++) begin
            r0 = 6'(a);
            #1;
            chk($sformatf("cleared_reg%0d", a), d0, 32'h0);
        end
        $display("reset release: ready after 64 edges, all 64 registers read back");

        // Table-driven RUN vectors: check the pre-edge outputs, then commit the edge.
        for (int i = 0; i < 8; i++) begin
            we = vt[i].we; rw = vt[i].rw; dw = vt[i].dw;
            rsv = vt[i].rsv; rsv_addr = vt[i].rsv_addr;
            r0 = vt[i].r0; r1 = vt[i].r1;
            #1;
            chk($sformatf("v%0d_d0", i), d0, vt[i].exp_d0);
            chk($sformatf("v%0d_d1", i), d1, vt[i].exp_d1);
            chk($sformatf("v%0d_busy0", i), {31'b0, busy0}, {31'b0, vt[i].exp_b0});
            chk($sformatf("v%0d_busy1", i), {31'b0, busy1}, {31'b0, vt[i].exp_b1});
            $display("vec %0d: we=%0b rw=%0d dw=%h rsv=%0b ra=%0d r0=%0d r1=%0d -> d0=%h d1=%h b0=%0b b1=%0b",
                     i, we, rw, dw, rsv, rsv_addr, r0, r1, d0, d1, busy0, busy1);
            @(negedge clk);
        end
        idle();

        // Forwarding: reg 3 holds 0x11, then is rewritten while being read.
        we = 1'b1; rw = 6'd3; dw = 32'h11; r0 = 6'd0;
        @(negedge clk);
        we = 1'b1; rw = 6'd3; dw = 32'hA5A5A5A5; r0 = 6'd3;
        #1;
`ifdef IREG_BYPASS_EN
        chk("bypass_same_cycle", d0, 32'hA5A5A5A5);
`else
        chk("no_bypass_same_cycle", d0, 32'h11);
`endif
        @(negedge clk);
        idle();
        #1;
        chk("bypass_after_edge", d0, 32'hA5A5A5A5);
        $display("bypass: same-cycle write to reg 3 read back, d0=%h", d0);

        // Writes and reserves issued during a clear are ignored.
        @(negedge clk);
        reset_pulse();
        clear_seq(10, 0);
        r0 = 6'd2;
        #1;
        chk("clear_ignored_d0", d0, 32'h0);
        chk("clear_ignored_busy0", {31'b0, busy0}, 32'd0);
        $display("clear: write/reserve to reg 2 at cycle 10 ignored, d0=%h busy0=%0b", d0, busy0);

        // Reset mid-operation, then mid-clear, then a full clear.
        @(negedge clk);
        we = 1'b1; rw = 6'd63; dw = 32'h12345678;
        rsv = 1'b1; rsv_addr = 6'd1;
        @(negedge clk);
        idle();
        r0 = 6'd63; r1 = 6'd1;
        #1;
        chk("pre_reset_reg63", d0, 32'h12345678);
        chk("pre_reset_busy1", {31'b0, busy1}, 32'd1);
        @(negedge clk);
        reset_pulse();
        clear_seq(0, 30);
        // Storage is not reset and the first clear stopped early: reg 63 survives.
        chk("aborted_clear_reg63", d0, 32'h12345678);
        chk("aborted_clear_busy1", {31'b0, busy1}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_seq(0, 0);
        r0 = 6'd63; r1 = 6'd1;
        #1;
        chk("restart_reg63", d0, 32'h0);
        chk("restart_busy1", {31'b0, busy1}, 32'd0);
        $display("reset mid-op: reg63=%h busy(reg1)=%0b after full restart", d0, busy1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
